// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with KMP fallback, optional overlap,
// sample enable and a saturating match counter.
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8,
    localparam int            SW      = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    output logic             y,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int NS = 2 ** SW;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Longest prefix of PATTERN (shorter than N) that is a suffix of the
    // first k pattern bits followed by bit b; evaluated only at elaboration.
    function automatic logic [SW-1:0] calc_next(input int k, input logic b);
        int          len;
        int          pos;
        logic        ok;
        logic        sbit;
        logic [SW-1:0] best;
        len  = k + 1;
        best = '0;
        for (int j = 1; j < N; j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    pos  = len - j + i;
                    sbit = (pos == k) ? b : PATTERN[N-1-pos];
                    if (PATTERN[N-1-i] != sbit) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = SW'(j);
                end
            end
        end
        return best;
    endfunction

    logic [SW-1:0] next_on0 [NS];
    logic [SW-1:0] next_on1 [NS];

    generate
        for (genvar k = 0; k < NS; k++) begin : g_tbl
            if (k < N) begin : g_valid
                assign next_on0[k] = calc_next(k, 1'b0);
                assign next_on1[k] = calc_next(k, 1'b1);
            end else begin : g_unused
                assign next_on0[k] = '0;
                assign next_on1[k] = '0;
            end
        end
    endgenerate

    logic [SW-1:0] fallback;
    logic          completes;

    always_comb begin
        fallback  = x ? next_on1[state] : next_on0[state];
        completes = (state == SW'(N - 1)) && (x == PATTERN[0]);
    end

    // After a full match the table already yields the longest proper border,
    // which is exactly the overlapping restart point.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= '0;
            y         <= 1'b0;
            match_cnt <= '0;
        end else if (en) begin
            y <= completes;
            if (completes) begin
                if (match_cnt != '1) begin
                    match_cnt <= match_cnt + CNT_ONE;
                end
                state <= OVERLAP ? fallback : '0;
            end else begin
                state <= fallback;
            end
        end else begin
            y <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param across four parameter sets
// sharing one input stream.
module tb_seq_detector_param;

    typedef struct {
        logic        y;
        logic [31:0] st;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    logic x;
    logic en;

    logic       def_y, nov_y, n2_y, fb_y;
    logic [2:0] def_state, nov_state, fb_state;
    logic [1:0] n2_state;
    logic [7:0] def_cnt, nov_cnt, fb_cnt;
    logic [1:0] n2_cnt;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    seq_detector_param u_def (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .y(def_y), .state(def_state), .match_cnt(def_cnt)
    );

    seq_detector_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .y(nov_y), .state(nov_state), .match_cnt(nov_cnt)
    );

    seq_detector_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_n2 (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .y(n2_y), .state(n2_state), .match_cnt(n2_cnt)
    );

    seq_detector_param #(.PATTERN(4'b1101)) u_fb (
        .clk(clk), .reset(reset), .x(x), .en(en),
        .y(fb_y), .state(fb_state), .match_cnt(fb_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic r, input logic xv, input logic e);
        reset = r;
        x     = xv;
        en    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input logic ey, input int est, input int ecnt);
        exp_t e;
        e.y   = ey;
        e.st  = 32'(est);
        e.cnt = 32'(ecnt);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        apply_reset();
        apply_stimulus(1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) push_exp(1'b0, 0, 0);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        e = sb.pop_front();
        tests_run++;
        if (def_y !== e.y || 32'(def_state) !== e.st || 32'(def_cnt) !== e.cnt) begin
            tests_failed++;
            $display("[TB] FAIL reset_def: y=%b state=%0d cnt=%0d, expected 0/0/0", def_y, def_state, def_cnt);
        end
        e = sb.pop_front();
        tests_run++;
        if (nov_y !== e.y || 32'(nov_state) !== e.st || 32'(nov_cnt) !== e.cnt) begin
            tests_failed++;
            $display("[TB] FAIL reset_nov: y=%b state=%0d cnt=%0d, expected 0/0/0", nov_y, nov_state, nov_cnt);
        end
        e = sb.pop_front();
        tests_run++;
        if (n2_y !== e.y || 32'(n2_state) !== e.st || 32'(n2_cnt) !== e.cnt) begin
            tests_failed++;
            $display("[TB] FAIL reset_n2: y=%b state=%0d cnt=%0d, expected 0/0/0", n2_y, n2_state, n2_cnt);
        end
        e = sb.pop_front();
        tests_run++;
        if (fb_y !== e.y || 32'(fb_state) !== e.st || 32'(fb_cnt) !== e.cnt) begin
            tests_failed++;
            $display("[TB] FAIL reset_fb: y=%b state=%0d cnt=%0d, expected 0/0/0", fb_y, fb_state, fb_cnt);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        int   st_exp[7]  = '{1, 2, 3, 1, 2, 3, 1};
        int   cnt_exp[7] = '{0, 0, 0, 1, 1, 1, 2};
        logic y_exp[7]   = '{0, 0, 0, 1, 0, 0, 1};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            push_exp(y_exp[i], st_exp[i], cnt_exp[i]);
            apply_stimulus(1'b0, bits[6-i], 1'b1);
            e = sb.pop_front();
            tests_run++;
            if (def_y !== e.y || 32'(def_state) !== e.st || 32'(def_cnt) !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL overlap bit %0d: y=%b state=%0d cnt=%0d, expected y=%b state=%0d cnt=%0d",
                         i + 1, def_y, def_state, def_cnt, e.y, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits = 7'b1011011;
        int   st_exp[7]  = '{1, 2, 3, 0, 0, 1, 1};
        int   cnt_exp[7] = '{0, 0, 0, 1, 1, 1, 1};
        logic y_exp[7]   = '{0, 0, 0, 1, 0, 0, 0};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            push_exp(y_exp[i], st_exp[i], cnt_exp[i]);
            apply_stimulus(1'b0, bits[6-i], 1'b1);
            e = sb.pop_front();
            tests_run++;
            if (nov_y !== e.y || 32'(nov_state) !== e.st || 32'(nov_cnt) !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL non_overlap bit %0d: y=%b state=%0d cnt=%0d, expected y=%b state=%0d cnt=%0d",
                         i + 1, nov_y, nov_state, nov_cnt, e.y, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic x_seq[7]   = '{1, 0, 1, 0, 0, 0, 1};
        logic en_seq[7]  = '{1, 1, 1, 0, 0, 0, 1};
        int   st_exp[7]  = '{1, 2, 3, 3, 3, 3, 1};
        int   cnt_exp[7] = '{0, 0, 0, 0, 0, 0, 1};
        logic y_exp[7]   = '{0, 0, 0, 0, 0, 0, 1};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            push_exp(y_exp[i], st_exp[i], cnt_exp[i]);
            apply_stimulus(1'b0, x_seq[i], en_seq[i]);
            e = sb.pop_front();
            tests_run++;
            if (def_y !== e.y || 32'(def_state) !== e.st || 32'(def_cnt) !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL enable_hold step %0d: y=%b state=%0d cnt=%0d, expected y=%b state=%0d cnt=%0d",
                         i + 1, def_y, def_state, def_cnt, e.y, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_pattern();
        logic r_seq[5]   = '{0, 0, 0, 1, 0};
        logic x_seq[5]   = '{1, 0, 1, 1, 1};
        int   st_exp[5]  = '{1, 2, 3, 0, 1};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            push_exp(1'b0, st_exp[i], 0);
            apply_stimulus(r_seq[i], x_seq[i], 1'b1);
            e = sb.pop_front();
            tests_run++;
            if (def_y !== e.y || 32'(def_state) !== e.st || 32'(def_cnt) !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid step %0d: y=%b state=%0d cnt=%0d, expected y=%b state=%0d cnt=%0d",
                         i + 1, def_y, def_state, def_cnt, e.y, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic en_seq[7]  = '{1, 1, 1, 1, 1, 1, 0};
        int   cnt_exp[7] = '{0, 1, 2, 3, 3, 3, 3};
        logic y_exp[7]   = '{0, 1, 1, 1, 1, 1, 0};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            push_exp(y_exp[i], 1, cnt_exp[i]);
            apply_stimulus(1'b0, 1'b1, en_seq[i]);
            e = sb.pop_front();
            tests_run++;
            if (n2_y !== e.y || 32'(n2_state) !== e.st || 32'(n2_cnt) !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back step %0d: y=%b state=%0d cnt=%0d, expected y=%b state=%0d cnt=%0d",
                         i + 1, n2_y, n2_state, n2_cnt, e.y, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_fallback();
        logic x_seq[5]   = '{1, 1, 1, 0, 1};
        int   st_exp[5]  = '{1, 2, 2, 3, 1};
        int   cnt_exp[5] = '{0, 0, 0, 0, 1};
        logic y_exp[5]   = '{0, 0, 0, 0, 1};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            push_exp(y_exp[i], st_exp[i], cnt_exp[i]);
            apply_stimulus(1'b0, x_seq[i], 1'b1);
            e = sb.pop_front();
            tests_run++;
            if (fb_y !== e.y || 32'(fb_state) !== e.st || 32'(fb_cnt) !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL fallback bit %0d: y=%b state=%0d cnt=%0d, expected y=%b state=%0d cnt=%0d",
                         i + 1, fb_y, fb_state, fb_cnt, e.y, e.st, e.cnt);
            end
        end
    endtask

    // History-window reference for 1011: a match needs the last four accepted
    // bits to equal the pattern, plus four fresh bits in non-overlap mode.
    task automatic test_random();
        logic [3:0] hist = 4'b0000;
        int   acc = 0;
        int   since_nov = 0;
        int   cnt_ov = 0;
        int   cnt_nov = 0;
        logic xv, ev, m, y_ov, y_nov;
        exp_t e;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            xv    = 1'($urandom_range(0, 1));
            ev    = ($urandom_range(0, 3) != 0);
            y_ov  = 1'b0;
            y_nov = 1'b0;
            if (ev) begin
                hist = {hist[2:0], xv};
                acc++;
                since_nov++;
                m     = (acc >= 4) && (hist == 4'b1011);
                y_ov  = m;
                y_nov = m && (since_nov >= 4);
                if (y_nov) since_nov = 0;
            end
            if (y_ov) cnt_ov++;
            if (y_nov) cnt_nov++;
            push_exp(y_ov, 0, cnt_ov);
            push_exp(y_nov, 0, cnt_nov);
            apply_stimulus(1'b0, xv, ev);
            e = sb.pop_front();
            tests_run++;
            if (def_y !== e.y || 32'(def_cnt) !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL random_overlap step %0d: y=%b cnt=%0d, expected y=%b cnt=%0d",
                         i, def_y, def_cnt, e.y, e.cnt);
            end
            e = sb.pop_front();
            tests_run++;
            if (nov_y !== e.y || 32'(nov_cnt) !== e.cnt) begin
                tests_failed++;
                $display("[TB] FAIL random_non_overlap step %0d: y=%b cnt=%0d, expected y=%b cnt=%0d",
                         i, nov_y, nov_cnt, e.y, e.cnt);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        x     = 1'b0;
        en    = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_enable_hold();
        test_reset_mid_pattern();
        test_back_to_back();
        test_fallback();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector. It samples a 1-bit stream `x` and raises a one-cycle registered pulse on `y` each time the last `N` accepted bits equal `PATTERN`. It supports overlapping and non-overlapping match modes, a sample-enable input, and a saturating match counter. It is the generalised successor to the lab-8 fixed-pattern FSM: the pattern, its length and the overlap mode are now parameters, and the state register is exposed for debug.

## Interface
- `N`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011: pattern `[N-1:0]`; `PATTERN[N-1]` is the first bit received.
- `OVERLAP`, 1: 1 = overlapping matches; 0 = non-overlapping.
- `CNT_W`, 8: match counter width; legal range 1..32.
- Derived: `SW = $clog2(N+1)`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `x`  in  1  serial data bit.
- `en`  in  1  sample qualifier; `x` is accepted only when `en`=1.
- `y`  out  1  match pulse, registered.
- `state`  out  SW  current matched-prefix length, 0..N-1.
- `match_cnt`  out  CNT_W  number of matches, saturating.

## Operation
- FSM with states S0..S(N-1); Sk means the first k pattern bits are matched.
  - Invariant: `state` is the longest proper prefix of `PATTERN` that is a suffix of the accepted history.
  - After a completed match, the state is chosen by mode (see below).
- Accepted bit `x` in state Sk, with k<N-1:
  - If `x == PATTERN[N-1-k]`, go to S(k+1).
  - Otherwise, go to S(j), where j is the longest prefix of `PATTERN` that is a suffix of (matched k bits, x). This is the KMP failure fallback, not a blind return to S0.
- Accepted bit completing a match (state S(N-1), `x == PATTERN[0]`):
  - `y` goes to 1 on that edge.
  - `match_cnt` increments on that edge, unless it is all-ones; it then holds (saturation).
  - OVERLAP=1: next state = S(b), where b is the longest proper border of `PATTERN`.
  - OVERLAP=0: next state = S0.
- Fallback and border values are derived from `PATTERN` at elaboration. There is no runtime pattern load.
- `en`=0:
  - `state` and `match_cnt` hold.
  - `y` is driven 0 on that edge.
- `reset`=1 overrides `en` and `x`. On that edge: `state`=0, `y`=0, `match_cnt`=0.
- Reset values: `y`=0, `state`=0, `match_cnt`=0.
- Arithmetic: `match_cnt` is unsigned, width CNT_W, with no wrap-around.

## Timing
- Latency: `y` rises on the same rising edge that samples the completing bit. It is high for exactly one cycle unless the next accepted bit completes another match.
  - Back-to-back `y` is possible only with OVERLAP=1 and a pattern whose border has length N-1 (e.g. 1111).
- `state` and `match_cnt` update on the same edge as `y`.
- Reset applied mid-pattern discards the partial match. The first accepted bit after reset starts from S0.
- Reset and `en`=1 asserted together: reset wins, and no match is counted.
- `en` toggling between bits does not break a match. Only accepted bits form the history.

## Test plan
- Defaults; reset for 1 cycle; then `x` = 1,0,1,1,0,1,1 with `en`=1, one bit per cycle.
  - `y` pulses after bits 4 and 7.
  - `state` after each bit: 1,2,3,1,2,3,1.
  - `match_cnt` ends at 2.
- Same stream with OVERLAP=0:
  - `y` pulses after bit 4 only.
  - `state` sequence: 1,2,3,0,0,1,1.
  - `match_cnt`=1.
- Defaults; `x` = 1,0,1, then hold `en`=0 for 3 cycles with `x`=0, then `en`=1, `x`=1.
  - `state` holds at 3 while `en`=0.
  - `y` pulses after the final bit.
  - `match_cnt`=1.
- Defaults; `x` = 1,0,1, then assert `reset` for 1 cycle, then `x`=1.
  - After reset: `state`=0, `y`=0, `match_cnt`=0.
  - After the last bit: `state`=1, with no `y` pulse.
- N=2, PATTERN=2'b11, OVERLAP=1, CNT_W=2; `x`=1 for 6 cycles.
  - `y` high on cycles 2..6 continuously.
  - `match_cnt` = 1,2,3,3,3 (saturates at 3).
- Fallback check with PATTERN=4'b1101; `x` = 1,1,1,0,1.
  - `state` = 1,2,2,3; `y` pulses after bit 5.
